// File: rtl/mux4reg_rr_arbiter.sv
// Round-robin arbiter/sequencer for a registered 4:1 mux with per-owner burst locking.
// Latency: word granted in cycle N is on out with out_valid=1 in cycle N+1; one word/cycle.
// Backpressure: while out_valid=1 and sink_ready=0 no grants issue and all state holds.
module mux4reg_rr_arbiter #(
  parameter int bits      = 3,
  parameter int MAX_BURST = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [3:0]      lock,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  input  logic [bits-1:0] C,
  input  logic [bits-1:0] D,
  input  logic            sink_ready,
  output logic [3:0]      gnt,
  output logic [bits-1:0] out,
  output logic            out_valid,
  output logic [1:0]      out_src
);

  // Burst counter needs at least one bit even when locking is disabled.
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    BURST  = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic [CW-1:0]   burst_cnt;

  logic            ld;
  logic            win_vld;
  logic [1:0]      win_idx;
  logic [bits-1:0] sel_dat;
  logic [CW-1:0]   base_cnt;
  logic            keep_lock;

  // Output register may be refilled when empty or being consumed this cycle.
  assign ld = !out_valid || sink_ready;

  // Rotating priority search: scan downward so the nearest set bit at/after ptr wins.
  always_comb begin
    win_idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        win_idx = ptr + 2'(i);
      end
    end
  end

  // Grant only exists when a load slot is open; held at zero while in reset.
  assign win_vld = reset && ld && (|req);
  assign gnt     = win_vld ? (4'b0001 << win_idx) : 4'b0000;

  // Datapath select: 00=A, 01=B, 10=C, 11=D.
  always_comb begin
    sel_dat = A;
    case (win_idx)
      2'd0: sel_dat = A;
      2'd1: sel_dat = B;
      2'd2: sel_dat = C;
      2'd3: sel_dat = D;
      default: sel_dat = A;
    endcase
  end

  // A burst continues only for the owner already holding the pointer; anyone else starts fresh.
  always_comb begin
    base_cnt  = '0;
    if ((state == BURST) && (win_idx == ptr)) begin
      base_cnt = burst_cnt;
    end
    keep_lock = lock[win_idx] && (int'(base_cnt) < (MAX_BURST - 1));
  end

  // Sequencer: output register, source tag, pointer, burst count and state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      burst_cnt <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_src   <= 2'd0;
    end else if (ld) begin
      if (|req) begin
        out       <= sel_dat;
        out_src   <= win_idx;
        out_valid <= 1'b1;
        if (keep_lock) begin
          ptr       <= win_idx;
          burst_cnt <= base_cnt + 1'b1;
          state     <= BURST;
        end else begin
          ptr       <= win_idx + 2'd1;
          burst_cnt <= '0;
          state     <= STREAM;
        end
      end else begin
        // Nothing to send: drain and go idle; pointer keeps its position.
        out_valid <= 1'b0;
        burst_cnt <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mux4reg_rr_arbiter.sv
// Directed bench for mux4reg_rr_arbiter: table of per-cycle vectors plus a reset sequence.
// Latency: each row checks comb gnt and the registers loaded by the previous row.
// Backpressure: rows drive sink_ready low to exercise hold behaviour.
module tb_mux4reg_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] lock;
  logic [2:0] A, B, C, D;
  logic       sink_ready;
  logic [3:0] gnt;
  logic [2:0] out_w;
  logic       out_valid;
  logic [1:0] out_src;

  int checks = 0;
  int passed = 0;

  mux4reg_rr_arbiter #(.bits(3), .MAX_BURST(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .lock       (lock),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .sink_ready (sink_ready),
    .gnt        (gnt),
    .out        (out_w),
    .out_valid  (out_valid),
    .out_src    (out_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic       rdy;
    logic [2:0] a, b, c, d;
    logic [3:0] exp_gnt;
    logic       exp_valid;
    logic [2:0] exp_out;
    logic [1:0] exp_src;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t v(input logic [3:0] rq, input logic [3:0] lk, input logic rdy,
                             input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                             input logic [2:0] d, input logic [3:0] eg, input logic ev,
                             input logic [2:0] eo, input logic [1:0] es);
    vec_t r;
    r.req = rq; r.lock = lk; r.rdy = rdy;
    r.a = a; r.b = b; r.c = c; r.d = d;
    r.exp_gnt = eg; r.exp_valid = ev; r.exp_out = eo; r.exp_src = es;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    // Expected registered values are those loaded by the previous row.
    tbl[0]  = v(4'hF, 4'h0, 1, 1, 2, 3, 4, 4'b0001, 0, 0, 0);
    tbl[1]  = v(4'hF, 4'h0, 1, 1, 2, 3, 4, 4'b0010, 1, 1, 0);
    tbl[2]  = v(4'hF, 4'h0, 1, 1, 2, 3, 4, 4'b0100, 1, 2, 1);
    tbl[3]  = v(4'hF, 4'h0, 1, 1, 2, 3, 4, 4'b1000, 1, 3, 2);
    tbl[4]  = v(4'hF, 4'h0, 1, 1, 2, 3, 4, 4'b0001, 1, 4, 3);
    tbl[5]  = v(4'h0, 4'h0, 1, 1, 2, 3, 4, 4'b0000, 1, 1, 0);
    tbl[6]  = v(4'h0, 4'h0, 1, 1, 2, 3, 4, 4'b0000, 0, 1, 0);
    // Burst lock on A: four grants, then B once, then A again.
    tbl[7]  = v(4'b0001, 4'b0001, 1, 5, 2, 3, 4, 4'b0001, 0, 1, 0);
    tbl[8]  = v(4'b0011, 4'b0001, 1, 6, 2, 3, 4, 4'b0001, 1, 5, 0);
    tbl[9]  = v(4'b0011, 4'b0001, 1, 7, 2, 3, 4, 4'b0001, 1, 6, 0);
    tbl[10] = v(4'b0011, 4'b0001, 1, 1, 2, 3, 4, 4'b0001, 1, 7, 0);
    tbl[11] = v(4'b0011, 4'b0001, 1, 1, 2, 3, 4, 4'b0010, 1, 1, 0);
    tbl[12] = v(4'b0011, 4'b0001, 1, 3, 2, 3, 4, 4'b0001, 1, 2, 1);
    tbl[13] = v(4'b0000, 4'b0000, 1, 1, 2, 3, 4, 4'b0000, 1, 3, 0);
    // B locked for two grants, then drops req: C wins, then D, A.
    tbl[14] = v(4'b0010, 4'b0010, 1, 1, 6, 3, 4, 4'b0010, 0, 3, 0);
    tbl[15] = v(4'b0010, 4'b0010, 1, 1, 2, 3, 4, 4'b0010, 1, 6, 1);
    tbl[16] = v(4'b1101, 4'b0010, 1, 1, 2, 3, 4, 4'b0100, 1, 2, 1);
    tbl[17] = v(4'b1101, 4'b0000, 1, 1, 2, 3, 4, 4'b1000, 1, 3, 2);
    tbl[18] = v(4'b1101, 4'b0000, 1, 1, 2, 3, 4, 4'b0001, 1, 4, 3);
    // Backpressure with out=5 held for three cycles, then consume+grant together.
    tbl[19] = v(4'b0100, 4'b0000, 1, 1, 2, 5, 4, 4'b0100, 1, 1, 0);
    tbl[20] = v(4'b0011, 4'b0000, 0, 1, 2, 5, 4, 4'b0000, 1, 5, 2);
    tbl[21] = v(4'b0011, 4'b0000, 0, 1, 2, 5, 4, 4'b0000, 1, 5, 2);
    tbl[22] = v(4'b0011, 4'b0000, 0, 1, 2, 5, 4, 4'b0000, 1, 5, 2);
    tbl[23] = v(4'b0011, 4'b0000, 1, 1, 2, 5, 4, 4'b0001, 1, 5, 2);
    tbl[24] = v(4'b0011, 4'b0000, 1, 1, 2, 3, 4, 4'b0010, 1, 1, 0);
    // Drain after a single word from D; pointer wraps to A.
    tbl[25] = v(4'b1000, 4'b0000, 1, 1, 2, 3, 4, 4'b1000, 1, 2, 1);
    tbl[26] = v(4'b0000, 4'b0000, 1, 1, 2, 3, 4, 4'b0000, 1, 4, 3);
    tbl[27] = v(4'b0000, 4'b0000, 1, 1, 2, 3, 4, 4'b0000, 0, 4, 3);
    tbl[28] = v(4'hF,    4'b0000, 1, 1, 2, 3, 4, 4'b0001, 0, 4, 3);
    tbl[29] = v(4'b0000, 4'b0000, 1, 1, 2, 3, 4, 4'b0000, 1, 1, 0);

    reset = 1'b0; req = 4'hF; lock = 4'h0; sink_ready = 1'b1;
    A = 3'd1; B = 3'd2; C = 3'd3; D = 3'd4;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt",   8'(gnt),       8'h0);
    chk("rst_valid", 8'(out_valid), 8'h0);
    chk("rst_out",   8'(out_w),     8'h0);
    chk("rst_src",   8'(out_src),   8'h0);
    reset = 1'b1;

    for (int i = 0; i < 30; i++) begin
      req = tbl[i].req; lock = tbl[i].lock; sink_ready = tbl[i].rdy;
      A = tbl[i].a; B = tbl[i].b; C = tbl[i].c; D = tbl[i].d;
      #3;
      chk($sformatf("row%0d_gnt", i),   8'(gnt),       8'(tbl[i].exp_gnt));
      chk($sformatf("row%0d_valid", i), 8'(out_valid), 8'(tbl[i].exp_valid));
      chk($sformatf("row%0d_out", i),   8'(out_w),     8'(tbl[i].exp_out));
      chk($sformatf("row%0d_src", i),   8'(out_src),   8'(tbl[i].exp_src));
      @(posedge clock);
      #1;
    end

    // Enter a B burst (pointer left at B), then reset asynchronously mid-cycle.
    req = 4'b0010; lock = 4'b0010; sink_ready = 1'b1;
    A = 3'd1; B = 3'd6; C = 3'd3; D = 3'd4;
    #3;
    chk("burst_b_gnt", 8'(gnt), 8'b0010);
    @(posedge clock);
    #1;
    req = 4'hF;
    #1;
    chk("burst_b_valid", 8'(out_valid), 8'h1);
    chk("burst_b_out",   8'(out_w),     8'd6);
    chk("burst_b_gnt2",  8'(gnt),       8'b0010);
    reset = 1'b0;
    #1;
    chk("arst_out",   8'(out_w),     8'h0);
    chk("arst_valid", 8'(out_valid), 8'h0);
    chk("arst_src",   8'(out_src),   8'h0);
    chk("arst_gnt",   8'(gnt),       8'h0);
    @(posedge clock);
    #1;
    chk("arst_hold_gnt", 8'(gnt), 8'h0);
    lock = 4'h0;
    reset = 1'b1;
    #2;
    chk("post_rst_gnt", 8'(gnt), 8'b0001);
    @(posedge clock);
    #1;
    chk("post_rst_out",   8'(out_w),     8'd1);
    chk("post_rst_valid", 8'(out_valid), 8'h1);
    chk("post_rst_src",   8'(out_src),   8'h0);
    chk("post_rst_next",  8'(gnt),       8'b0010);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
